// File: rtl/turf_evhdr_pkg.sv
// Shared parameters, address field slices and FSM encoding
// for the TURF event header buffer (optional HDR_CHECKSUM_EN).
package turf_evhdr_pkg;

    localparam int NBUF      = 4;
    localparam int HDR_WORDS = 22;
    localparam int WORD_W    = 16;
    localparam int BUF_W     = 2;
    localparam int WCNT_W    = 5;

    localparam int BUF_MSB  = 7;
    localparam int BUF_LSB  = 6;
    localparam int WORD_MSB = 5;
    localparam int WORD_LSB = 0;

    // Index of the checksum word, one past the last RAM word.
    localparam logic [WCNT_W-1:0] CSUM_WORD = WCNT_W'(HDR_WORDS);

`ifdef HDR_CHECKSUM_EN
    localparam logic [WCNT_W-1:0] LAST_WORD = CSUM_WORD;
`else
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(HDR_WORDS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        RELEASE
    } state_e;

endpackage

// File: rtl/turf_event_header_buffer_if.sv
// Header readout stream: data/valid/ready/last plus buffer index.
// master = header buffer (source), slave = readout consumer.
interface turf_evhdr_if;
    import turf_evhdr_pkg::*;

    logic [WORD_W-1:0] hdr_dat;
    logic              hdr_valid;
    logic              hdr_ready;
    logic              hdr_last;
    logic [BUF_W-1:0]  hdr_buffer;

    modport master (
        output hdr_dat,
        output hdr_valid,
        output hdr_last,
        output hdr_buffer,
        input  hdr_ready
    );

    modport slave (
        input  hdr_dat,
        input  hdr_valid,
        input  hdr_last,
        input  hdr_buffer,
        output hdr_ready
    );

endinterface

// File: rtl/turf_evhdr_order_fifo.sv
// Completion-order queue, NBUF entries of buffer index.
// Ports: clk_i, rst_i, push_i/push_buf_i, pop_i, head_o, empty_o.
module turf_evhdr_order_fifo
    import turf_evhdr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [BUF_W-1:0] push_buf_i,
    input  logic             pop_i,
    output logic [BUF_W-1:0] head_o,
    output logic             empty_o
);

    logic [BUF_W-1:0] mem_q [NBUF];
    logic [BUF_W-1:0] rd_q, rd_d;
    logic [BUF_W-1:0] wr_q, wr_d;
    logic [BUF_W:0]   cnt_q, cnt_d;
    logic             pop;

    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign pop     = pop_i && !empty_o;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_i) begin
            wr_d = wr_q + 1'b1;
        end
        cnt_d = cnt_q + (BUF_W+1)'(push_i)
                      - (BUF_W+1)'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= push_buf_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turf_event_header_buffer.sv
// Captures event headers into a 4x64 RAM and streams completed
// buffers in completion order. Ports: clk33_i, rst_i, event_*_i
// write/done side, hdr_m stream, buffer_pending_o, overflow_o,
// collision_o. Macro HDR_CHECKSUM_EN appends an XOR word.
module turf_event_header_buffer
    import turf_evhdr_pkg::*;
(
    input  logic              clk33_i,
    input  logic              rst_i,
    input  logic [7:0]        event_addr_i,
    input  logic [WORD_W-1:0] event_dat_i,
    input  logic              event_wr_i,
    input  logic              event_done_i,
    turf_evhdr_if.master      hdr_m,
    output logic [NBUF-1:0]   buffer_pending_o,
    output logic              overflow_o,
    output logic              collision_o
);

    logic [WORD_W-1:0] ram [2**8];

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] word_q, word_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [WORD_W-1:0] dat_q, dat_d;
    logic [NBUF-1:0]   pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              coll_q, coll_d;

    logic              fifo_empty;
    logic [BUF_W-1:0]  fifo_head;
    logic              pop;
    logic              accept;
    logic              valid;
    logic              last;
    logic [BUF_W-1:0]  done_buf;
    logic [WORD_W-1:0] rd_data;

    assign done_buf = event_addr_i[BUF_MSB:BUF_LSB];
    assign rd_data  = ram[{buf_q, 1'b0, word_q}];

    // Writes are never blocked; they always land before any read
    // of the same cycle's done.
    always_ff @(posedge clk33_i) begin
        if (event_wr_i) begin
            ram[event_addr_i] <= event_dat_i;
        end
    end

    turf_evhdr_order_fifo u_fifo (
        .clk_i      (clk33_i),
        .rst_i      (rst_i),
        .push_i     (accept),
        .push_buf_i (done_buf),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty)
    );

`ifdef HDR_CHECKSUM_EN
    logic [WORD_W-1:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (state_q == IDLE) begin
            xor_d = '0;
        end else if (valid && hdr_m.hdr_ready
                     && word_q != CSUM_WORD) begin
            xor_d = xor_q ^ dat_q;
        end
    end

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        buf_d   = buf_q;
        dat_d   = dat_q;
        pop     = 1'b0;
        valid   = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    buf_d   = fifo_head;
                    word_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                dat_d = rd_data;
`ifdef HDR_CHECKSUM_EN
                if (word_q == CSUM_WORD) begin
                    dat_d = xor_q;
                end
`endif
                state_d = PRESENT;
            end
            PRESENT: begin
                valid = 1'b1;
                last  = (word_q == LAST_WORD);
                if (hdr_m.hdr_ready) begin
                    if (last) begin
                        state_d = RELEASE;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            RELEASE: begin
                pop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A done for the buffer being released this cycle is accepted:
    // the release clears the bit and the new done sets it again.
    always_comb begin
        accept = event_done_i
                 && (!pend_q[done_buf]
                     || (pop && buf_q == done_buf));
        pend_d = pend_q;
        if (pop) begin
            pend_d[buf_q] = 1'b0;
        end
        if (accept) begin
            pend_d[done_buf] = 1'b1;
        end
        ovf_d  = ovf_q | (event_done_i && !accept);
        coll_d = coll_q
                 | (event_wr_i && state_q != IDLE
                    && done_buf == buf_q);
    end

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            buf_q   <= '0;
            dat_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            buf_q   <= buf_d;
            dat_q   <= dat_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            coll_q  <= coll_d;
        end
    end

    assign hdr_m.hdr_dat    = dat_q;
    assign hdr_m.hdr_valid  = valid;
    assign hdr_m.hdr_last   = last;
    assign hdr_m.hdr_buffer = buf_q;
    assign buffer_pending_o = pend_q;
    assign overflow_o       = ovf_q;
    assign collision_o      = coll_q;

endmodule

// File: tb/tb_turf_event_header_buffer.sv
// Self-checking bench for turf_event_header_buffer.
// Scoreboard of streamed words plus table-driven order checks.
module tb_turf_event_header_buffer;
    import turf_evhdr_pkg::*;

`ifdef HDR_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic [15:0] wdat = '0;
    logic        wr = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  pend;
    logic        ovf;
    logic        coll;

    turf_evhdr_if hdr ();

    turf_event_header_buffer dut (
        .clk33_i          (clk),
        .rst_i            (rst),
        .event_addr_i     (addr),
        .event_dat_i      (wdat),
        .event_wr_i       (wr),
        .event_done_i     (done),
        .hdr_m            (hdr),
        .buffer_pending_o (pend),
        .overflow_o       (ovf),
        .collision_o      (coll)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  b;
        logic [15:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        logic [1:0]  b;
        logic [15:0] base;
        logic [3:0]  pend_after;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   nwords = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] b,
                            input logic [15:0] base);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            exp_q.push_back('{b, base + 16'(i),
                (!CSUM && i == HDR_WORDS - 1)});
            x ^= base + 16'(i);
        end
        if (CSUM) exp_q.push_back('{b, x, 1'b1});
    endtask

    task automatic write_hdr(input logic [1:0] b,
                             input logic [15:0] base);
        for (int i = 0; i < HDR_WORDS; i++) begin
            @(posedge clk); #1;
            addr = {b, 6'(i)};
            wdat = base + 16'(i);
            wr   = 1'b1;
            done = (i == HDR_WORDS - 1);
        end
        @(posedge clk); #1;
        wr   = 1'b0;
        done = 1'b0;
        push_exp(b, base);
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (nwords < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (nwords < n) check("wait_words", nwords, n);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pend != 0)
               && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_q", exp_q.size(), 0);
        check("drain_pend", pend, 0);
    endtask

    // Scoreboard: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (!rst && hdr.hdr_valid && hdr.hdr_ready) begin
            nwords++;
            if (exp_q.size() == 0) begin
                check("extra_word", hdr.hdr_dat, 16'hxxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word", {13'd0, hdr.hdr_buffer,
                      hdr.hdr_last, hdr.hdr_dat},
                      {13'd0, e.b, e.l, e.d});
            end
        end
    end

    vec_t tv[3];

    initial begin
        logic [3:0] prev;
        int st;
        int k;
        tv[0] = '{2'd1, 16'hB100, 4'b1001};
        tv[1] = '{2'd3, 16'hB300, 4'b0001};
        tv[2] = '{2'd0, 16'hB000, 4'b0000};
        hdr.hdr_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", hdr.hdr_valid, 0);
        check("rst_last", hdr.hdr_last, 0);
        check("rst_dat", hdr.hdr_dat, 0);
        check("rst_buf", hdr.hdr_buffer, 0);
        check("rst_pend", pend, 0);
        check("rst_ovf", ovf, 0);
        check("rst_coll", coll, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single header from buffer 2.
        write_hdr(2'd2, 16'hA000);
        @(negedge clk);
        check("t1_pend", pend, 4'b0100);
        drain();

        // Three headers complete while the consumer stalls.
        hdr.hdr_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_hdr(tv[i].b, tv[i].base);
        @(negedge clk);
        check("t2_pend", pend, 4'b1011);
        prev = pend;
        hdr.hdr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (pend == prev && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("t2_order", pend, tv[i].pend_after);
            prev = pend;
        end
        drain();

        // Stall mid-header.
        st = nwords;
        write_hdr(2'd1, 16'hC100);
        wait_words(st + 5);
        @(posedge clk); #1;
        hdr.hdr_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_valid", hdr.hdr_valid, 1);
            check("t3_dat", hdr.hdr_dat, exp_q[0].d);
        end
        hdr.hdr_ready = 1'b1;
        drain();

        // Done arriving in the release cycle of the same buffer.
        write_hdr(2'd0, 16'hE000);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(hdr.hdr_valid && hdr.hdr_last)
                   && k < 500);
        check("t4_last_seen", hdr.hdr_last, 1);
        @(posedge clk); #1;
        addr = 8'h00;
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        push_exp(2'd0, 16'hE000);
        @(negedge clk);
        check("t4_rel_pend", pend, 4'b0001);
        check("t4_rel_ovf", ovf, 0);
        drain();

        // Second done while pending and not streaming.
        hdr.hdr_ready = 1'b0;
        write_hdr(2'd3, 16'hE300);
        write_hdr(2'd0, 16'hE000);
        @(posedge clk); #1;
        addr = 8'h00;
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(negedge clk);
        check("t4_ovf", ovf, 1);
        check("t4_pend", pend, 4'b1001);
        hdr.hdr_ready = 1'b1;
        drain();
        repeat (10) @(negedge clk);
        check("t4_idle", hdr.hdr_valid, 0);
        check("t4_coll0", coll, 0);

        // Collision, then reset mid-header.
        st = nwords;
        write_hdr(2'd2, 16'hD200);
        wait_words(st + 3);
        @(posedge clk); #1;
        addr = {2'd2, 6'h30};
        wdat = 16'hFFFF;
        wr   = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        check("t5_coll", coll, 1);
        wait_words(st + 7);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t5_valid", hdr.hdr_valid, 0);
        check("t5_pend", pend, 0);
        check("t5_coll", coll, 0);
        check("t5_ovf", ovf, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Words 1..22; checksum build appends 0x0017.
        write_hdr(2'd1, 16'h0001);
        drain();
        check("end_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
